mux4_rr_scheduler: RTL

- Round-robin scheduler that shares one 4-to-1 selection path among four requesters.
- Tracks request lines, drives the 2-bit select and one-hot grant, bounds each grant to a dwell limit, and registers the selected bit with a valid flag.
- Sits between four board-level sources (switch/key-driven requests and data bits) and a single output LED or downstream consumer.

---
 rtl/mux4_rr_scheduler_if.sv | 33 +++
 rtl/mux4_rr_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/mux4_rr_scheduler_if.sv
// Bundle of request, data and grant signals shared between the four
// board-level sources and the round-robin scheduler.
interface mux4_rr_scheduler_if;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out;
    logic       out_valid;
    logic       busy;

    // Source side: raises requests and presents data, observes the grant.
    modport master (
        output req,
        output data_in,
        input  grant,
        input  sel,
        input  out,
        input  out_valid,
        input  busy
    );

    // Scheduler side: samples requests and data, owns grant and output.
    modport slave (
        input  req,
        input  data_in,
        output grant,
        output sel,
        output out,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler sharing one 4-to-1 selection path among four
// requesters. Each grant is bounded by a dwell limit, every release is
// followed by a single idle cycle, and the selected data bit is registered
// together with a valid flag one cycle behind the grant.
module mux4_rr_scheduler #(
    parameter int MAX_DWELL = 8,
    parameter int CW        = 8
) (
    input logic           clock,
    input logic           reset,
    mux4_rr_scheduler_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value on which the current holder must let go.
    localparam logic [CW-1:0] DWELL_LAST = CW'(MAX_DWELL - 1);

    state_t        state;
    logic [3:0]    grant_q;
    logic [1:0]    sel_q;
    logic          out_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [CW-1:0] dwell;
    logic [1:0]    last;

    logic [1:0]    winner;
    logic          release_now;

    // Rotating-priority search: scan upward from the source after the last
    // one served, wrapping, so the last holder ranks behind everyone else.
    function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                               input logic [1:0] prev);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = prev + 2'(k);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Winner among the currently asserted requests.
    always_comb begin
        winner = pick_winner(bus.req, last);
    end

    // Holder lets go when it drops its request or its dwell budget is spent.
    always_comb begin
        release_now = (bus.req[sel_q] == 1'b0) || (dwell == DWELL_LAST);
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant_q     <= 4'b0000;
            sel_q       <= 2'd0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dwell       <= '0;
            last        <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    out_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                    if (|bus.req) begin
                        state   <= GRANT;
                        sel_q   <= winner;
                        grant_q <= 4'b0001 << winner;
                        busy_q  <= 1'b1;
                        dwell   <= '0;
                    end
                end
                GRANT: begin
                    out_q       <= bus.data_in[sel_q];
                    out_valid_q <= 1'b1;
                    if (release_now) begin
                        state   <= IDLE;
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                        last    <= sel_q;
                        dwell   <= '0;
                    end else begin
                        dwell   <= dwell + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule
